// File: rtl/reg_file_dec_pkg.sv
// Shared constants for the register file and its neighbouring decode / write-back stages.
package reg_file_dec_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

    localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/reg_file_dec_if.sv
// Write-back write port, decode read ports and debug word enables of the register file.
interface reg_file_dec_if
    import reg_file_dec_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic                    we;
    logic [ADDR_W-1:0]       waddr;
    logic [DATA_W-1:0]       wdata;
    logic [ADDR_W-1:0]       ra_addr;
    logic [ADDR_W-1:0]       rb_addr;
    logic [DATA_W-1:0]       ra_data;
    logic [DATA_W-1:0]       rb_data;
    logic [2**ADDR_W-1:0]    wen_onehot;

    modport master (
        output we, waddr, wdata, ra_addr, rb_addr,
        input  ra_data, rb_data, wen_onehot
    );

    modport slave (
        input  we, waddr, wdata, ra_addr, rb_addr,
        output ra_data, rb_data, wen_onehot
    );

endinterface

// File: rtl/reg_file_dec_dec5_to_32.sv
// One-hot write-address decoder built from gate primitives; output bit 0 is tied low
// because register 0 is never stored.
module dec5_to_32
    import reg_file_dec_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  wire                  i_en,
    input  wire [ADDR_W-1:0]     i_addr,
    output wire [2**ADDR_W-1:0]  o_onehot
);

    wire [ADDR_W-1:0] w_addr_n;

    for (genvar b = 0; b < ADDR_W; b++) begin : g_inv
        not u_inv (w_addr_n[b], i_addr[b]);
    end

    assign o_onehot[0] = 1'b0;

    // Each enable is an AND chain of en and the true/complement literal of every address bit.
    for (genvar i = 1; i < 2**ADDR_W; i++) begin : g_word
        wire [ADDR_W:0]   w_chain;
        wire [ADDR_W-1:0] w_lit;

        assign w_chain[0] = i_en;

        for (genvar b = 0; b < ADDR_W; b++) begin : g_bit
            if (((i >> b) & 1) == 1) begin : g_hi
                assign w_lit[b] = i_addr[b];
            end else begin : g_lo
                assign w_lit[b] = w_addr_n[b];
            end
            and u_and (w_chain[b+1], w_chain[b], w_lit[b]);
        end

        assign o_onehot[i] = w_chain[ADDR_W];
    end

endmodule

// File: rtl/reg_file_dec.sv
// 31-entry register file (r0 hardwired to zero) with one write port, two combinational
// read ports and same-cycle write-to-read forwarding.
module reg_file_dec
    import reg_file_dec_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_file_dec_if.slave   bus
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [NUM_REGS-1:0] w_wen;
    logic [DATA_W-1:0]   w_rd [NUM_REGS];
    logic                w_fwd_a;
    logic                w_fwd_b;

    dec5_to_32 #(
        .ADDR_W   (ADDR_W)
    ) u_dec (
        .i_en     (bus.we),
        .i_addr   (bus.waddr),
        .o_onehot (w_wen)
    );

    assign bus.wen_onehot = w_wen;
    assign w_rd[0]        = '0;

    // An X enable evaluates false in the if, so an unknown address never writes anything.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_wen[i]) begin
                r_q <= bus.wdata;
            end
        end

        assign w_rd[i] = r_q;
    end

    // Forward compares run in parallel with the decoder so it stays off the read path.
    assign w_fwd_a = bus.we && (bus.waddr == bus.ra_addr);
    assign w_fwd_b = bus.we && (bus.waddr == bus.rb_addr);

    assign bus.ra_data = (bus.ra_addr == ZERO_IDX) ? '0 :
                         w_fwd_a                   ? bus.wdata :
                                                     w_rd[bus.ra_addr];

    assign bus.rb_data = (bus.rb_addr == ZERO_IDX) ? '0 :
                         w_fwd_b                   ? bus.wdata :
                                                     w_rd[bus.rb_addr];

    ap_no_x_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({bus.we, bus.waddr}));

    ap_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(w_wen));

endmodule

// File: tb/tb_reg_file_dec.sv
// Scoreboard bench for reg_file_dec: a reference register model predicts each read/decode
// result when stimulus is driven, and the prediction is popped and compared once it settles.
module tb_reg_file_dec;
    import reg_file_dec_pkg::*;

    typedef struct packed {
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] wen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m_regs [32];
    exp_t        exp_q [$];
    int          n_chk = 0;
    int          n_pass = 0;

    reg_file_dec_if bus ();

    reg_file_dec dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0)          return 32'h0;
        if (we && (wa == a))    return wd;
        return m_regs[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        bus.we      = we;
        bus.waddr   = wa;
        bus.wdata   = wd;
        bus.ra_addr = ra;
        bus.rb_addr = rb;
        e.ra  = m_read(ra, we, wa, wd);
        e.rb  = m_read(rb, we, wa, wd);
        e.wen = (we && wa != 5'd0) ? (32'h1 << wa) : 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("ra_data", bus.ra_data, e.ra);
            chk("rb_data", bus.rb_data, e.rb);
            chk("wen_onehot", bus.wen_onehot, e.wen);
            chk("onehot0", 32'($countones(bus.wen_onehot) <= 1), 32'd1);
        end
    endtask

    // One clocked cycle: drive after the edge, check at the falling edge, then let the
    // model take the write that the coming rising edge will store.
    task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk);
        #1;
        drive(we, wa, wd, ra, rb);
        @(negedge clk);
        check_out();
        if (rst_n && we && wa != 5'd0) m_regs[wa] = wd;
    endtask

    // Combinational look between edges, no clock involved.
    task automatic probe(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        drive(we, wa, wd, ra, rb);
        #1;
        check_out();
    endtask

    initial begin
        m_clear();
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.ra_addr = '0; bus.rb_addr = '0;

        // reset held
        #2;
        probe(1'b0, 5'd0, 32'h0, 5'd3, 5'd17);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) cyc(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        // write then read
        cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
        chk("wr5_wen", bus.wen_onehot, 32'h0000_0020);
        cyc(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        chk("rd5_a", bus.ra_data, 32'hDEAD_BEEF);
        chk("rd5_b", bus.rb_data, 32'hDEAD_BEEF);

        // register 0
        cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5);
        chk("r0_wen", bus.wen_onehot, 32'h0);
        chk("r0_fwd", bus.ra_data, 32'h0);
        for (int i = 0; i < 32; i++) cyc(1'b0, 5'd0, 32'h0, 5'(i), 5'(i));

        // same-cycle forwarding
        cyc(1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0);
        cyc(1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7);
        chk("fwd_pre", bus.ra_data, 32'h2222_2222);
        cyc(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        chk("fwd_post", bus.ra_data, 32'h2222_2222);

        // back-to-back writes to one index
        cyc(1'b1, 5'd12, 32'hAAAA_0001, 5'd12, 5'd0);
        cyc(1'b1, 5'd12, 32'hAAAA_0002, 5'd12, 5'd12);
        cyc(1'b0, 5'd0, 32'h0, 5'd12, 5'd12);

        // async reset mid-operation
        for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 32'(i), 5'(i), 5'(32 - i));
        cyc(1'b0, 5'd0, 32'h0, 5'd3, 5'd30);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_clear();
        probe(1'b0, 5'd0, 32'h0, 5'd3, 5'd30);
        probe(1'b0, 5'd0, 32'h0, 5'd31, 5'd9);
        probe(1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd1);
        @(posedge clk);
        #1;
        probe(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        rst_n = 1'b1;
        #1;
        probe(1'b0, 5'd0, 32'h0, 5'd9, 5'd1);
        for (int i = 0; i < 32; i++) cyc(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        // random sweep
        for (int n = 0; n < 10000; n++) begin
            logic [4:0]  wa, ra, rb;
            logic        we;
            logic [31:0] wd;
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cyc(we, wa, wd, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
